gray_codec: RTL and testbench
=============================

GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 Parameter WIDTH, default 4: code word width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 3: pipeline register stages; legal range 1..WIDTH; illegal values SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_flush  input  1  synchronous clear of all in-flight beats.
REQ-006 i_valid  input  1  input beat present.
REQ-007 o_ready  output  1  block accepts input beat this cycle.
REQ-008 i_mode  input  1  conversion direction per beat: 0 = Gray->binary, 1 = binary->Gray.
REQ-009 i_data  input  WIDTH  input code word.
REQ-010 o_valid  output  1  output beat present.
REQ-011 i_ready  input  1  downstream accepts output beat.
REQ-012 o_mode  output  1  direction of the presented output beat.
REQ-013 o_data  output  WIDTH  converted code word.
REQ-014 o_busy  output  1  high while any stage holds a valid beat.

Function
REQ-015 Input handshake SHALL complete when i_valid and o_ready are both high; output handshake SHALL complete when o_valid and i_ready are both high.
REQ-016 Mode 0: o_data[k] SHALL equal the XOR of i_data[WIDTH-1:k] for every bit k.
REQ-017 Mode 1: o_data SHALL equal i_data XOR (i_data >> 1), logical shift.
REQ-018 Mode SHALL travel with its beat; beats of mixed mode SHALL flow back-to-back without bubbles.
REQ-019 Mode 0 work SHALL be split MSB-first: each stage resolves ceil(WIDTH/STAGES) bits, the last stage resolving the remainder.
REQ-020 Mode 1 SHALL be computed in stage 0 and carried unchanged through later stages.
REQ-021 Latency with i_ready held high SHALL be exactly STAGES cycles from input handshake to o_valid.
REQ-022 Throughput SHALL be one beat per cycle while i_ready is high.
REQ-023 Stage k SHALL load when it is empty or stage k+1 loads; the last stage loads when it is empty or i_ready is high.
REQ-024 o_ready SHALL equal the stage-0 load condition AND NOT i_flush; a combinational ready path through all stages is permitted.
REQ-025 A stalled stage SHALL hold its data, mode and valid bit unchanged; no beat SHALL be dropped or duplicated.
REQ-026 o_data and o_mode SHALL remain stable while o_valid is high and i_ready is low.
REQ-027 Pipeline full (all stages valid) with i_ready low SHALL drive o_ready low.
REQ-028 i_flush SHALL clear every stage valid bit at the next edge, block input acceptance that cycle and suppress any output handshake that cycle; it SHALL win over all simultaneous events.
REQ-029 o_busy SHALL be the OR of all stage valid bits.

Reset
REQ-030 rst_n low SHALL immediately clear all valid bits, all stage data and mode registers, and drive o_valid, o_data, o_mode and o_busy to 0.
REQ-031 Assertion of rst_n mid-stream SHALL discard all in-flight beats; after deassertion the first accepted beat SHALL emerge after STAGES cycles.
REQ-032 o_ready SHALL be 0 while rst_n is low, and SHALL be high in the first cycle after deassertion if i_flush is low.

Structure
REQ-033 Package gray_codec_pkg SHALL hold the mode enum (GC_G2B = 0, GC_B2G = 1) and the per-stage bit-count function.
REQ-034 Sub-module gray_codec_stage SHALL implement one pipeline stage: registers, load logic and partial XOR; gray_codec SHALL instantiate STAGES copies in a generate loop.

Verification
REQ-035 WIDTH=4, STAGES=3, mode 0, i_data 4'b1011 -> o_data 4'b1101, o_valid exactly 3 cycles after the handshake.
REQ-036 Mode 1, i_data 4'b1101 -> o_data 4'b1011; alternating modes over 16 back-to-back beats -> 16 correct outputs in order, no bubbles.
REQ-037 Exhaustive WIDTH=8, STAGES=8: all 256 codes round-tripped through mode 1 then mode 0 -> the original value each time.
REQ-038 Fill the pipeline, hold i_ready low 5 cycles -> o_ready low and o_data stable; release -> 3 beats drain in order, none lost.
REQ-039 i_flush and i_valid both high with the pipeline full -> no input accepted, o_valid 0 on the next cycle, o_busy 0.
REQ-040 Assert rst_n low mid-stream between clock edges -> o_valid and o_data go to 0 immediately; after release a new beat appears with latency STAGES.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// Shared types and elaboration-time helpers for the Gray/binary codec pipeline.
// The helpers decide how many Gray->binary bits each stage resolves.
package gray_codec_pkg;

  typedef enum logic {
    GC_G2B = 1'b0,
    GC_B2G = 1'b1
  } gc_mode_e;

  // Count of MSB-side bits already resolved before stage k (ceil split).
  function automatic int stage_done(input int width, input int stages, input int k);
    int per;
    per = (width + stages - 1) / stages;
    if (k * per > width) begin
      return width;
    end else begin
      return k * per;
    end
  endfunction

  function automatic int stage_bits(input int width, input int stages, input int k);
    if (k == stages - 1) begin
      return width - stage_done(width, stages, k);
    end else begin
      return stage_done(width, stages, k + 1) - stage_done(width, stages, k);
    end
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline stage: beat registers, elastic load logic and the partial
// MSB-first prefix XOR for Gray->binary (stage 0 also performs binary->Gray).
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit FIRST = 1'b0,
  parameter int DONE  = 0,
  parameter int NBITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  gc_mode_e         in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_load,
  output logic             load,
  output logic             valid,
  output gc_mode_e         mode,
  output logic [WIDTH-1:0] data
);

  localparam int TOP = WIDTH - 1 - DONE;
  localparam int BOT = WIDTH - DONE - NBITS;

  logic             valid_r;
  gc_mode_e         mode_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] res_s;

  assign load  = ~valid_r | next_load;
  assign valid = valid_r;
  assign mode  = mode_r;
  assign data  = data_r;

  // Bits above TOP are already binary; resolve TOP..BOT from the bit above.
  always_comb begin
    res_s = in_data;
    if (FIRST == 1'b1 && in_mode == GC_B2G) begin
      res_s = in_data ^ (in_data >> 1);
    end else if (in_mode == GC_G2B) begin
      for (int j = WIDTH - 2; j >= 0; j--) begin
        if (j <= TOP && j >= BOT) begin
          res_s[j] = res_s[j+1] ^ res_s[j];
        end else begin
          res_s[j] = res_s[j];
        end
      end
    end else begin
      res_s = in_data;
    end
  end

  // Beat registers: flush beats everything, a stalled stage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      mode_r  <= GC_G2B;
      data_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= in_valid;
      mode_r  <= in_mode;
      data_r  <= res_s;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/gray_codec.sv
// Pipelined Gray<->binary converter with valid/ready handshakes; the
// conversion direction travels with each beat through STAGES stages.
module gray_codec
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_mode,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy
);

  if (WIDTH < 2 || WIDTH > 32 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("gray_codec: WIDTH must be 2..32 and STAGES 1..WIDTH");
  end

  logic [STAGES-1:0] busy_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             prev_valid_s;
    gc_mode_e         prev_mode_s;
    logic [WIDTH-1:0] prev_data_s;
    logic             next_load_s;
    logic             load_s;
    logic             valid_s;
    gc_mode_e         mode_s;
    logic [WIDTH-1:0] data_s;

    if (k == 0) begin : g_head
      assign prev_valid_s = i_valid & o_ready;
      assign prev_mode_s  = gc_mode_e'(i_mode);
      assign prev_data_s  = i_data;
    end else begin : g_link
      assign prev_valid_s = g_stage[k-1].valid_s;
      assign prev_mode_s  = g_stage[k-1].mode_s;
      assign prev_data_s  = g_stage[k-1].data_s;
    end

    if (k == STAGES - 1) begin : g_tail
      assign next_load_s = i_ready;
    end else begin : g_mid
      assign next_load_s = g_stage[k+1].load_s;
    end

    gray_codec_stage #(
      .WIDTH(WIDTH),
      .FIRST(k == 0),
      .DONE (stage_done(WIDTH, STAGES, k)),
      .NBITS(stage_bits(WIDTH, STAGES, k))
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (i_flush),
      .in_valid (prev_valid_s),
      .in_mode  (prev_mode_s),
      .in_data  (prev_data_s),
      .next_load(next_load_s),
      .load     (load_s),
      .valid    (valid_s),
      .mode     (mode_s),
      .data     (data_s)
    );

    assign busy_s[k] = valid_s;
  end

  // Flush masks the output beat so no downstream handshake can complete.
  assign o_ready = g_stage[0].load_s & ~i_flush & rst_n;
  assign o_valid = g_stage[STAGES-1].valid_s & ~i_flush;
  assign o_mode  = g_stage[STAGES-1].mode_s;
  assign o_data  = g_stage[STAGES-1].data_s;
  assign o_busy  = |busy_s;

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench: table vectors plus directed corner sequences on a
// 4-bit/3-stage instance, and an exhaustive round trip on an 8-bit/8-stage one.
module tb_gray_codec;
  localparam int W = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, i_flush, i_valid, o_ready, i_mode, o_valid, i_ready, o_mode, o_busy;
  logic [W-1:0] i_data, o_data;
  logic b_i_valid, b_o_ready, b_i_mode, b_o_valid, b_o_mode, b_o_busy;
  logic [7:0] b_i_data, b_o_data;

  gray_codec #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_mode(o_mode), .o_data(o_data), .o_busy(o_busy));

  gray_codec #(.WIDTH(8), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_flush(1'b0), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .i_mode(b_i_mode), .i_data(b_i_data), .o_valid(b_o_valid), .i_ready(1'b1),
    .o_mode(b_o_mode), .o_data(b_o_data), .o_busy(b_o_busy));

  typedef struct packed { logic mode; logic [W-1:0] data; } beat_t;
  typedef struct { logic mode; logic [W-1:0] din; logic [W-1:0] dout; } vec_t;

  beat_t exp_q[$];
  beat_t cur_exp;
  beat_t pop_e;
  logic [7:0] b_q[$];
  logic [7:0] codes[256];
  vec_t tbl[8];
  int n_cmp = 0, n_bad = 0, n_pop = 0, mark = 0, first_out = 0, last_out = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_g2b(input logic [31:0] v, input int w);
    logic [31:0] b;
    b = '0;
    b[w-1] = v[w-1];
    for (int k = w - 2; k >= 0; k--) b[k] = b[k+1] ^ v[k];
    return b;
  endfunction

  function automatic logic [31:0] m_b2g(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (i_flush) begin
      chk("flush_o_valid", 32'(o_valid), 32'd0);
      chk("flush_o_ready", 32'(o_ready), 32'd0);
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(o_valid), 32'd0);
        end else begin
          pop_e = exp_q.pop_front();
          chk("out_data", 32'(o_data), 32'(pop_e.data));
          chk("out_mode", 32'(o_mode), 32'(pop_e.mode));
          if (n_pop == mark) first_out = cyc;
          last_out = cyc;
          n_pop++;
        end
      end
      if (i_valid && o_ready) exp_q.push_back(cur_exp);
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_o_valid) b_q.push_back(b_o_data);
  end

  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] e);
    bit acc;
    acc = 1'b0;
    i_valid = 1'b1; i_mode = m; i_data = d;
    cur_exp.mode = m; cur_exp.data = e;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    i_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic latency(input string name, input logic m, input logic [W-1:0] d,
                         input logic [W-1:0] e);
    int lat;
    lat = 0;
    i_valid = 1'b1; i_mode = m; i_data = d;
    cur_exp.mode = m; cur_exp.data = e;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (t == 0) i_valid = 1'b0;
      lat++;
      if (o_valid) break;
    end
    chk(name, 32'(lat), 32'(S));
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    int t;
    rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ready = 1'b1;
    b_i_valid = 1'b0; b_i_mode = 1'b0; b_i_data = '0;
    cur_exp = '0;

    tbl[0] = '{1'b0, 4'b1011, 4'b1101};
    tbl[1] = '{1'b1, 4'b1101, 4'b1011};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000};
    tbl[3] = '{1'b0, 4'b1000, 4'b1111};
    tbl[4] = '{1'b0, 4'b1111, 4'b1010};
    tbl[5] = '{1'b1, 4'b1111, 4'b1000};
    tbl[6] = '{1'b1, 4'b0110, 4'b0101};
    tbl[7] = '{1'b1, 4'b1000, 4'b1100};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(o_ready), 32'd1);
    @(posedge clk); #1;

    latency("latency_g2b", 1'b0, 4'b1011, 4'b1101);

    mark = n_pop;
    for (int i = 0; i < 8; i++) send(tbl[i].mode, tbl[i].din, tbl[i].dout);
    wait_drain();
    chk("table_count", 32'(n_pop - mark), 32'd8);

    mark = n_pop;
    for (int i = 0; i < 16; i++) begin
      d = W'($urandom_range(0, 15));
      if (i % 2 == 0) send(1'b0, d, W'(m_g2b(32'(d), W)));
      else send(1'b1, d, W'(m_b2g(32'(d))));
    end
    wait_drain();
    chk("alt_count", 32'(n_pop - mark), 32'd16);
    chk("alt_no_bubble", 32'(last_out - first_out), 32'd15);

    i_ready = 1'b0;
    send(1'b1, 4'b0001, 4'b0001);
    send(1'b1, 4'b0010, 4'b0011);
    send(1'b1, 4'b0100, 4'b0110);
    i_valid = 1'b1; i_mode = 1'b0; i_data = 4'hA;
    repeat (5) begin
      @(negedge clk);
      chk("stall_o_ready", 32'(o_ready), 32'd0);
      chk("stall_o_valid", 32'(o_valid), 32'd1);
      chk("stall_o_data", 32'(o_data), 32'h1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    mark = n_pop;
    wait_drain();
    chk("stall_drain_count", 32'(n_pop - mark), 32'd3);

    i_ready = 1'b0;
    send(1'b0, 4'b0011, 4'b0010);
    send(1'b0, 4'b0101, 4'b0110);
    send(1'b0, 4'b0111, 4'b0101);
    i_valid = 1'b1; i_flush = 1'b1; i_mode = 1'b1; i_data = 4'h5;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_next_o_valid", 32'(o_valid), 32'd0);
    chk("flush_next_o_busy", 32'(o_busy), 32'd0);
    i_ready = 1'b1;
    latency("latency_post_flush", 1'b1, 4'b1101, 4'b1011);

    repeat (4) send(1'b1, 4'hF, 4'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o_data", 32'(o_data), 32'd0);
    chk("midrst_o_mode", 32'(o_mode), 32'd0);
    chk("midrst_o_busy", 32'(o_busy), 32'd0);
    chk("midrst_o_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    latency("latency_post_reset", 1'b0, 4'b1011, 4'b1101);

    b_q.delete();
    for (int v = 0; v < 256; v++) begin
      b_i_valid = 1'b1; b_i_mode = 1'b1; b_i_data = 8'(v);
      @(posedge clk); #1;
    end
    b_i_valid = 1'b0;
    t = 0;
    while (b_q.size() < 256 && t < 100) begin @(posedge clk); #1; t++; end
    chk("b2g_count", 32'(b_q.size()), 32'd256);
    for (int v = 0; v < 256; v++) begin
      codes[v] = (v < b_q.size()) ? b_q[v] : 8'h00;
      chk("b2g_code", 32'(codes[v]), m_b2g(32'(v)));
    end
    b_q.delete();
    for (int v = 0; v < 256; v++) begin
      b_i_valid = 1'b1; b_i_mode = 1'b0; b_i_data = codes[v];
      @(posedge clk); #1;
    end
    b_i_valid = 1'b0;
    t = 0;
    while (b_q.size() < 256 && t < 100) begin @(posedge clk); #1; t++; end
    chk("roundtrip_count", 32'(b_q.size()), 32'd256);
    for (int v = 0; v < 256; v++) begin
      chk("roundtrip", 32'((v < b_q.size()) ? b_q[v] : 8'h00), 32'(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
